// File: rtl/filter_output_fifo_pkg.sv
// -----------------------------------------------------------------------------
// filter_output_fifo_pkg
// Purpose : Constants shared between the filter core and its output FIFO.
//           Holds the native filtered-sample width, the default FIFO geometry
//           and the FIR/IIR mode encoding that travels with every sample.
// Contents: FILTER_DATA_W      width of one filtered sample
//           FIFO_DEPTH_DEFAULT default number of FIFO entries
//           DROP_CNT_W_DEFAULT default width of the drop counter
//           filter_mode_e      mode bit encoding (1 = FIR, 0 = IIR)
// -----------------------------------------------------------------------------
package filter_output_fifo_pkg;

   localparam int FILTER_DATA_W      = 8;
   localparam int FIFO_DEPTH_DEFAULT = 8;
   localparam int DROP_CNT_W_DEFAULT = 8;

   // The filter control bit that produced a sample is stored with that sample.
   typedef enum logic {
      MODE_IIR = 1'b0,
      MODE_FIR = 1'b1
   } filter_mode_e;

endpackage

// File: rtl/filter_output_fifo_if.sv
// -----------------------------------------------------------------------------
// filter_output_fifo_if
// Purpose : Bundles the producer side (sample_en/data_in/mode_in/flush), the
//           consumer handshake (out_valid/out_ready/out_data/out_mode) and the
//           status outputs (level/full/empty/drop_count) of the filter output
//           FIFO into one interface.
// Modports: slave  - the FIFO itself (receives samples, drives head/status)
//           master - whoever feeds samples and drains the FIFO
// Params  : DATA_W sample width, DEPTH entries (power of two, >= 2),
//           CNT_W drop counter width; AW is derived from DEPTH.
// -----------------------------------------------------------------------------
interface filter_output_fifo_if
   import filter_output_fifo_pkg::*;
#(
   parameter int DATA_W = FILTER_DATA_W,
   parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
   parameter int CNT_W  = DROP_CNT_W_DEFAULT
);

   localparam int AW = $clog2(DEPTH);

   logic              sample_en;
   logic [DATA_W-1:0] data_in;
   logic              mode_in;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_mode;
   logic [AW:0]       level;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  drop_count;

   modport slave (
      input  sample_en, data_in, mode_in, flush, out_ready,
      output out_valid, out_data, out_mode, level, full, empty, drop_count
   );

   modport master (
      output sample_en, data_in, mode_in, flush, out_ready,
      input  out_valid, out_data, out_mode, level, full, empty, drop_count
   );

endinterface

// File: rtl/filter_output_fifo_ram_2p.sv
// -----------------------------------------------------------------------------
// fifo_ram_2p
// Purpose : Storage array for the filter output FIFO. DEPTH words of WIDTH
//           bits, one synchronous write port and one combinational read port
//           so the head word is visible in the same cycle it is addressed.
//           The array has no reset; its contents are meaningless until written.
// Ports   : clock  rising-edge clock
//           we     write enable
//           waddr  write address
//           wdata  write data
//           raddr  read address
//           rdata  read data (combinational)
// -----------------------------------------------------------------------------
module fifo_ram_2p
   import filter_output_fifo_pkg::*;
#(
   parameter  int WIDTH = FILTER_DATA_W + 1,
   parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Plain register-file write; deliberately left without a reset so it maps
   // onto cheap storage. Validity of entries is tracked by the FIFO level.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/filter_output_fifo.sv
// -----------------------------------------------------------------------------
// filter_output_fifo
// Purpose : Output stage of the reconfigurable FIR/IIR filter. Captures each
//           filtered sample together with its FIR/IIR mode bit, buffers it in
//           a first-word-fall-through FIFO and drains it over valid/ready.
//           Samples arriving while the FIFO is full (and nothing leaves in the
//           same cycle) are discarded and counted in a saturating counter.
// Ports   : clock  rising-edge clock
//           reset  asynchronous, active-low reset
//           bus    filter_output_fifo_if.slave:
//                  sample_en/data_in/mode_in  incoming sample
//                  flush                      synchronous clear of contents
//                  out_valid/out_ready        consumer handshake
//                  out_data/out_mode          head entry (0 while empty)
//                  level/full/empty           fill status from registered level
//                  drop_count                 saturating count of dropped samples
// -----------------------------------------------------------------------------
module filter_output_fifo
   import filter_output_fifo_pkg::*;
#(
   parameter int DATA_W = FILTER_DATA_W,
   parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
   parameter int CNT_W  = DROP_CNT_W_DEFAULT
) (
   input logic                 clock,
   input logic                 reset,
   filter_output_fifo_if.slave bus
);

   localparam int                AW         = $clog2(DEPTH);
   localparam logic [AW:0]       LEVEL_FULL = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0]  DROP_MAX   = '1;

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level_q;
   logic [CNT_W-1:0] drop_q;
   logic             full_w;
   logic             empty_w;
   logic             pop;
   logic             push;
   logic             drop;
   logic             ram_we;
   logic [DATA_W:0]  wr_word;
   logic [DATA_W:0]  rd_word;

   // Status comes only from the registered level so full/empty/out_valid never
   // ripple combinationally from this cycle's inputs. A pop frees a slot in the
   // same cycle, which is why a push into a full FIFO is allowed alongside a pop.
   assign full_w  = (level_q == LEVEL_FULL);
   assign empty_w = (level_q == '0);
   assign pop     = !empty_w && bus.out_ready;
   assign push    = bus.sample_en && (!full_w || pop);
   assign drop    = bus.sample_en && full_w && !pop && !bus.flush;
   assign ram_we  = push && !bus.flush;
   assign wr_word = {bus.mode_in, bus.data_in};

   fifo_ram_2p #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (wr_word),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   // Pointer and level bookkeeping. Flush wins over any same-cycle push or pop.
   // Pointers wrap naturally because DEPTH is a power of two; the extra level
   // bit is what distinguishes full from empty when the pointers coincide.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Drop counter survives flush and only clears on reset. It sticks at its
   // maximum so a long overflow burst still reads as "lots" rather than wrapping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         drop_q <= '0;
      end else if (drop && (drop_q != DROP_MAX)) begin
         drop_q <= drop_q + CNT_W'(1);
      end
   end

   // The array is not reset, so the head is masked to zero whenever the FIFO is
   // empty; that keeps out_data/out_mode at 0 after reset and after flush.
   assign bus.out_valid  = !empty_w;
   assign bus.out_data   = empty_w ? '0 : rd_word[DATA_W-1:0];
   assign bus.out_mode   = empty_w ? 1'b0 : rd_word[DATA_W];
   assign bus.level      = level_q;
   assign bus.full       = full_w;
   assign bus.empty      = empty_w;
   assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_filter_output_fifo.sv
// -----------------------------------------------------------------------------
// tb_filter_output_fifo
// Purpose : Self-checking bench for filter_output_fifo. Directed scenarios for
//           ordering, overflow, full push+pop, flush and async reset, plus a
//           randomized phase, all compared against a queue-based model.
// -----------------------------------------------------------------------------
module tb_filter_output_fifo;
   import filter_output_fifo_pkg::*;

   localparam int DW       = 8;
   localparam int DEPTH    = 8;
   localparam int CW       = 8;
   localparam int DROP_SAT = (1 << CW) - 1;

   logic clock = 1'b0;
   logic reset = 1'b0;

   filter_output_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) bus ();

   filter_output_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: an ordered list of {mode,data} entries and a drop tally.
   logic [DW:0] model_q [$];
   int          model_drops = 0;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Compare every DUT output against what the model says should be visible.
   task automatic checkModel(input string where);
      logic [DW:0] head;
      int          n;
      n    = model_q.size();
      head = (n > 0) ? model_q[0] : '0;
      checkOutput({where, "/out_valid"},  32'(bus.out_valid),  32'(n > 0));
      checkOutput({where, "/out_data"},   32'(bus.out_data),   32'(head[DW-1:0]));
      checkOutput({where, "/out_mode"},   32'(bus.out_mode),   32'(head[DW]));
      checkOutput({where, "/level"},      32'(bus.level),      32'(n));
      checkOutput({where, "/full"},       32'(bus.full),       32'(n == DEPTH));
      checkOutput({where, "/empty"},      32'(bus.empty),      32'(n == 0));
      checkOutput({where, "/drop_count"}, 32'(bus.drop_count), 32'(model_drops));
   endtask

   // One clock edge of the model: flush empties everything; otherwise a sample
   // goes in if there is room before the edge or the head leaves on this edge.
   task automatic modelEdge(input logic se, input logic [DW-1:0] d, input logic m,
                            input logic fl, input logic rdy);
      bit was_full;
      bit did_pop;
      if (fl) begin
         model_q.delete();
      end else begin
         was_full = (model_q.size() == DEPTH);
         did_pop  = (model_q.size() > 0) && rdy;
         if (did_pop) begin
            void'(model_q.pop_front());
         end
         if (se) begin
            if (!was_full || did_pop) begin
               model_q.push_back({m, d});
            end else if (model_drops < DROP_SAT) begin
               model_drops++;
            end
         end
      end
   endtask

   // Drive one cycle of inputs from a falling edge, let the rising edge act,
   // then return to idle at the next falling edge and compare with the model.
   task automatic applyStimulus(input logic se, input logic [DW-1:0] d, input logic m,
                                input logic fl, input logic rdy);
      bus.sample_en = se;
      bus.data_in   = d;
      bus.mode_in   = m;
      bus.flush     = fl;
      bus.out_ready = rdy;
      @(posedge clock);
      modelEdge(se, d, m, fl, rdy);
      @(negedge clock);
      bus.sample_en = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      checkModel("cycle");
   endtask

   initial begin : main
      logic [DW-1:0] expect_heads [8];

      bus.sample_en = 1'b0;
      bus.data_in   = '0;
      bus.mode_in   = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // Scenario 1: reset values
      @(negedge clock);
      @(negedge clock);
      checkModel("reset");
      checkOutput("reset/out_data_zero", 32'(bus.out_data), 32'h0);
      reset = 1'b1;
      @(negedge clock);

      // Scenario 2: three samples, held, then drained in order
      applyStimulus(1'b1, 8'h11, MODE_FIR, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, MODE_IIR, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, MODE_FIR, 1'b0, 1'b0);
      checkOutput("t2/level", 32'(bus.level), 32'd3);
      checkOutput("t2/head_data", 32'(bus.out_data), 32'h11);
      checkOutput("t2/head_mode", 32'(bus.out_mode), 32'd1);
      expect_heads[0] = 8'h11;
      expect_heads[1] = 8'h22;
      expect_heads[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         checkOutput("t2/drain_head", 32'(bus.out_data), 32'(expect_heads[i]));
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("t2/empty", 32'(bus.empty), 32'd1);

      // Scenario 3: fill, overflow by two, drain only the first eight
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 8'(i), 1'(i % 2), 1'b0, 1'b0);
      end
      checkOutput("t3/full", 32'(bus.full), 32'd1);
      applyStimulus(1'b1, 8'hAA, MODE_FIR, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hBB, MODE_IIR, 1'b0, 1'b0);
      checkOutput("t3/drop_count", 32'(bus.drop_count), 32'd2);
      for (int i = 1; i <= 8; i++) begin
         checkOutput("t3/drain_head", 32'(bus.out_data), 32'(i));
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("t3/empty", 32'(bus.empty), 32'd1);

      // Scenario 4: push and pop together while full
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + i), MODE_IIR, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 8'hC5, MODE_FIR, 1'b0, 1'b1);
      checkOutput("t4/level", 32'(bus.level), 32'd8);
      checkOutput("t4/drop_count", 32'(bus.drop_count), 32'd2);
      for (int i = 0; i < 7; i++) begin
         expect_heads[i] = 8'(8'h41 + i);
      end
      expect_heads[7] = 8'hC5;
      for (int i = 0; i < 8; i++) begin
         checkOutput("t4/drain_head", 32'(bus.out_data), 32'(expect_heads[i]));
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      end

      // Scenario 5: flush with a concurrent sample, then immediate head
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'h60 + i), MODE_FIR, 1'b0, 1'b0);
      end
      checkOutput("t5/level_before", 32'(bus.level), 32'd5);
      applyStimulus(1'b1, 8'h99, MODE_FIR, 1'b1, 1'b1);
      checkOutput("t5/level_after", 32'(bus.level), 32'd0);
      checkOutput("t5/empty_after", 32'(bus.empty), 32'd1);
      checkOutput("t5/drop_kept", 32'(bus.drop_count), 32'd2);
      applyStimulus(1'b1, 8'h5A, MODE_IIR, 1'b0, 1'b0);
      checkOutput("t5/head_5a", 32'(bus.out_data), 32'h5A);
      checkOutput("t5/valid_5a", 32'(bus.out_valid), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Randomized traffic with occasional flushes
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
                       1'($urandom_range(0, 63) == 0),
                       1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 75)));
      end

      // Scenario 6: saturate the drop counter, then reset mid-drain
      while (model_q.size() < DEPTH) begin
         applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
      checkOutput("t6/drop_sat", 32'(bus.drop_count), 32'(DROP_SAT));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      bus.out_ready = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      model_q.delete();
      model_drops = 0;
      checkModel("async_reset");
      checkOutput("t6/rst_out_data", 32'(bus.out_data), 32'h0);
      checkOutput("t6/rst_drop", 32'(bus.drop_count), 32'h0);
      @(negedge clock);
      checkModel("held_reset");
      reset = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'b0,
                       1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
